adder_arbiter: RTL and testbench

- Shares one multi-cycle chunked adder/comparator unit (ADU) among NREQ requesters, e.g. PC incrementer, ALU and branch-compare paths.
- Arbitrates round-robin, latches the winner's op and operands, and holds them stable on the ADU for the whole operation.
- Waits for the ADU's done, then returns the result as a one-cycle response tagged with the requester id.
- Supports flush: the in-flight result is discarded without corrupting ADU state.

---
 rtl/adder_arbiter_if.sv | 35 +++
 rtl/adder_arbiter.sv | 114 +++++++++++
 tb/tb_adder_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/adder_arbiter_if.sv
// rtl/adder_arbiter_if.sv - operation type and requester/response bundle for adder_arbiter
package adder_arbiter_pkg;
  typedef enum logic [2:0] {
    OP_ADD, OP_SUB, OP_LT, OP_LTU, OP_EQ, OP_NE, OP_GE, OP_GEU
  } adderOp_t;
endpackage

interface adder_arbiter_if
  import adder_arbiter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NREQ  = 2
);
  localparam int IDW = ($clog2(NREQ) > 1) ? $clog2(NREQ) : 1;

  logic     [NREQ-1:0]            req_valid;
  logic     [NREQ-1:0]            req_ready;
  adderOp_t [NREQ-1:0]            req_op;
  logic     [NREQ-1:0][WIDTH-1:0] req_a;
  logic     [NREQ-1:0][WIDTH-1:0] req_b;
  logic                           rsp_valid;
  logic     [IDW-1:0]             rsp_id;
  logic     [WIDTH-1:0]           rsp_data;
  logic                           rsp_cond;

  modport master (
    output req_valid, req_op, req_a, req_b,
    input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_cond
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b,
    output req_ready, rsp_valid, rsp_id, rsp_data, rsp_cond
  );
endinterface

// File: rtl/adder_arbiter.sv
// rtl/adder_arbiter.sv - round-robin sharing of one multi-cycle adder/comparator unit
module adder_arbiter
  import adder_arbiter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NREQ  = 2
)
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  adder_arbiter_if.slave     bus,
  output logic               busy,
  output logic               adu_start,
  output adderOp_t           adu_op,
  output logic [WIDTH-1:0]   adu_a,
  output logic [WIDTH-1:0]   adu_b,
  input  logic [WIDTH-1:0]   adu_out,
  input  logic               adu_cond,
  input  logic               adu_done
);

  localparam int IDW = ($clog2(NREQ) > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t         state;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] lat_id;
  logic [IDW-1:0] grant_id;
  logic           grant_any;
  logic           grant_en;
  int             idx_full;

  // Scan ptr+1, ptr+2, ... so the last winner has the lowest priority next time.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    idx_full  = 0;
    for (int i = 1; i <= NREQ; i++) begin
      idx_full = (int'(ptr) + i) % NREQ;
      if (!grant_any && bus.req_valid[IDW'(idx_full)]) begin
        grant_any = 1'b1;
        grant_id  = IDW'(idx_full);
      end
    end
  end

  assign grant_en      = rst_n && (state == IDLE) && !flush && grant_any;
  assign bus.req_ready = grant_en ? (NREQ'(1) << grant_id) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      ptr           <= IDW'(NREQ - 1);
      lat_id        <= '0;
      adu_op        <= OP_ADD;
      adu_a         <= '0;
      adu_b         <= '0;
      adu_start     <= 1'b0;
      busy          <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_id    <= '0;
      bus.rsp_data  <= '0;
      bus.rsp_cond  <= 1'b0;
    end else begin
      bus.rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_en) begin
            adu_op    <= bus.req_op[grant_id];
            adu_a     <= bus.req_a[grant_id];
            adu_b     <= bus.req_b[grant_id];
            lat_id    <= grant_id;
            ptr       <= grant_id;
            adu_start <= 1'b1;
            busy      <= 1'b1;
            state     <= RUN;
          end
        end
        RUN: begin
          if (adu_done) begin
            // A flush coinciding with done still retires the op, just silently.
            if (!flush) begin
              bus.rsp_valid <= 1'b1;
              bus.rsp_id    <= lat_id;
              bus.rsp_data  <= adu_out;
              bus.rsp_cond  <= adu_cond;
            end
            adu_start <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end else if (flush) begin
            adu_start <= 1'b0;
            state     <= DRAIN;
          end
        end
        DRAIN: begin
          // The ADU keeps sequencing its chunks without start; wait it out.
          if (adu_done) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          adu_start <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adder_arbiter.sv
// tb/tb_adder_arbiter.sv - directed-vector bench for adder_arbiter with a 2-chunk ADU model
module tb_adder_arbiter;
  import adder_arbiter_pkg::*;

  localparam int WIDTH = 32;
  localparam int NREQ  = 2;
  localparam int NCYC  = 2;

  logic             clk   = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic             busy;
  logic             adu_start;
  adderOp_t         adu_op;
  logic [WIDTH-1:0] adu_a;
  logic [WIDTH-1:0] adu_b;
  logic [WIDTH-1:0] adu_out;
  logic             adu_cond;
  logic             adu_done;

  int applied     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  adder_arbiter_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus ();

  adder_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .bus       (bus),
    .busy      (busy),
    .adu_start (adu_start),
    .adu_op    (adu_op),
    .adu_a     (adu_a),
    .adu_b     (adu_b),
    .adu_out   (adu_out),
    .adu_cond  (adu_cond),
    .adu_done  (adu_done)
  );

  // ADU model: NCYC-cycle sequence once started, keeps going without start, done idles high.
  int   phase;
  logic running;
  logic adu_active;

  assign adu_active = running | adu_start;
  assign adu_done   = !adu_active || (phase == NCYC - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase   <= 0;
      running <= 1'b0;
    end else if (adu_active) begin
      if (phase == NCYC - 1) begin
        phase   <= 0;
        running <= 1'b0;
      end else begin
        phase   <= phase + 1;
        running <= 1'b1;
      end
    end
  end

  always_comb begin
    adu_out  = '0;
    adu_cond = 1'b0;
    case (adu_op)
      OP_ADD:  adu_out  = adu_a + adu_b;
      OP_SUB:  adu_out  = adu_a - adu_b;
      OP_LT:   adu_cond = $signed(adu_a) < $signed(adu_b);
      OP_LTU:  adu_cond = adu_a < adu_b;
      OP_EQ:   adu_cond = adu_a == adu_b;
      OP_NE:   adu_cond = adu_a != adu_b;
      OP_GE:   adu_cond = $signed(adu_a) >= $signed(adu_b);
      OP_GEU:  adu_cond = adu_a >= adu_b;
      default: adu_out  = '0;
    endcase
    if (adu_op != OP_ADD && adu_op != OP_SUB) adu_out = WIDTH'(adu_cond);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int r, input adderOp_t op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    bus.req_op[r]    = op;
    bus.req_a[r]     = a;
    bus.req_b[r]     = b;
    bus.req_valid[r] = 1'b1;
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.req_valid = 2'b11;
    step();
    #1;
    applied++; if (bus.req_ready !== 2'b00) begin miscompares++; $display("FAIL reset_ready: got %b want 00", bus.req_ready); end
    applied++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
    applied++; if (adu_start !== 1'b0) begin miscompares++; $display("FAIL reset_start: got %b want 0", adu_start); end
    applied++; if (bus.rsp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid); end
    applied++; if (bus.rsp_id !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_id: got %h want 0", bus.rsp_id); end
    applied++; if (bus.rsp_data !== 32'h0) begin miscompares++; $display("FAIL reset_rsp_data: got %h want 0", bus.rsp_data); end
    applied++; if (bus.rsp_cond !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_cond: got %b want 0", bus.rsp_cond); end
    applied++; if (adu_op !== OP_ADD) begin miscompares++; $display("FAIL reset_adu_op: got %0d want 0", adu_op); end
    applied++; if (adu_a !== 32'h0 || adu_b !== 32'h0) begin miscompares++; $display("FAIL reset_adu_ab: got %h/%h want 0/0", adu_a, adu_b); end
    bus.req_valid = 2'b00;
    rst_n         = 1'b1;
  endtask

  task automatic test_single_add();
    step();
    set_req(0, OP_ADD, 32'd5, 32'd7);
    #1;
    applied++; if (bus.req_ready !== 2'b01) begin miscompares++; $display("FAIL add_ready: got %b want 01", bus.req_ready); end
    step();
    bus.req_valid[0] = 1'b0;
    #1;
    applied++; if (adu_start !== 1'b1 || busy !== 1'b1) begin miscompares++; $display("FAIL add_run1: start/busy got %b/%b want 1/1", adu_start, busy); end
    applied++; if (adu_a !== 32'd5 || adu_b !== 32'd7) begin miscompares++; $display("FAIL add_operands: got %h/%h want 5/7", adu_a, adu_b); end
    applied++; if (bus.rsp_valid !== 1'b0) begin miscompares++; $display("FAIL add_early_rsp1: got %b want 0", bus.rsp_valid); end
    step();
    #1;
    applied++; if (adu_start !== 1'b1 || bus.rsp_valid !== 1'b0) begin miscompares++; $display("FAIL add_run2: start/rsp got %b/%b want 1/0", adu_start, bus.rsp_valid); end
    step();
    #1;
    applied++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 1'b0) begin miscompares++; $display("FAIL add_rsp: valid/id got %b/%h want 1/0", bus.rsp_valid, bus.rsp_id); end
    applied++; if (bus.rsp_data !== 32'd12 || bus.rsp_cond !== 1'b0) begin miscompares++; $display("FAIL add_data: got %h/%b want 0000000c/0", bus.rsp_data, bus.rsp_cond); end
    applied++; if (adu_start !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL add_idle: start/busy got %b/%b want 0/0", adu_start, busy); end
    step();
    #1;
    applied++; if (bus.rsp_valid !== 1'b0) begin miscompares++; $display("FAIL add_one_pulse: got %b want 0", bus.rsp_valid); end
  endtask

  task automatic test_carry();
    set_req(1, OP_ADD, 32'h0000FFFF, 32'h1);
    #1;
    applied++; if (bus.req_ready !== 2'b10) begin miscompares++; $display("FAIL carry_ready: got %b want 10", bus.req_ready); end
    step();
    bus.req_valid[1] = 1'b0;
    bus.req_a[1]     = 32'hDEADBEEF;
    bus.req_b[1]     = 32'h12345678;
    #1;
    applied++; if (adu_a !== 32'h0000FFFF || adu_b !== 32'h1) begin miscompares++; $display("FAIL carry_hold1: got %h/%h want 0000ffff/1", adu_a, adu_b); end
    step();
    #1;
    applied++; if (adu_a !== 32'h0000FFFF || adu_b !== 32'h1) begin miscompares++; $display("FAIL carry_hold2: got %h/%h want 0000ffff/1", adu_a, adu_b); end
    step();
    #1;
    applied++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 1'b1) begin miscompares++; $display("FAIL carry_rsp: valid/id got %b/%h want 1/1", bus.rsp_valid, bus.rsp_id); end
    applied++; if (bus.rsp_data !== 32'h00010000) begin miscompares++; $display("FAIL carry_data: got %h want 00010000", bus.rsp_data); end
  endtask

  task automatic test_compare();
    set_req(0, OP_LT, 32'hFFFFFFFF, 32'h1);
    #1;
    applied++; if (bus.req_ready !== 2'b01) begin miscompares++; $display("FAIL lt_ready: got %b want 01", bus.req_ready); end
    step();
    bus.req_valid[0] = 1'b0;
    step();
    step();
    #1;
    applied++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'h1 || bus.rsp_cond !== 1'b1) begin miscompares++; $display("FAIL lt_rsp: valid/data/cond got %b/%h/%b want 1/1/1", bus.rsp_valid, bus.rsp_data, bus.rsp_cond); end
    // New grant in the same cycle as the previous response.
    set_req(0, OP_LTU, 32'hFFFFFFFF, 32'h1);
    #1;
    applied++; if (bus.req_ready !== 2'b01) begin miscompares++; $display("FAIL ltu_ready: got %b want 01", bus.req_ready); end
    step();
    bus.req_valid[0] = 1'b0;
    step();
    step();
    #1;
    applied++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'h0 || bus.rsp_cond !== 1'b0) begin miscompares++; $display("FAIL ltu_rsp: valid/data/cond got %b/%h/%b want 1/0/0", bus.rsp_valid, bus.rsp_data, bus.rsp_cond); end
  endtask

  task automatic test_fairness();
    logic [1:0]  want_ready;
    logic [31:0] want_data;
    rst_n = 1'b0;
    set_req(0, OP_ADD, 32'd10, 32'd1);
    set_req(1, OP_SUB, 32'd10, 32'd3);
    step();
    rst_n = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      want_ready = (k % 2 == 1) ? 2'b10 : 2'b01;
      applied++; if (bus.req_ready !== want_ready) begin miscompares++; $display("FAIL rr_grant%0d: got %b want %b", k, bus.req_ready, want_ready); end
      if (k > 0) begin
        want_data = (k % 2 == 1) ? 32'd11 : 32'd7;
        applied++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 1'((k - 1) % 2) || bus.rsp_data !== want_data) begin miscompares++; $display("FAIL rr_rsp%0d: valid/id/data got %b/%h/%h want 1/%0d/%h", k - 1, bus.rsp_valid, bus.rsp_id, bus.rsp_data, (k - 1) % 2, want_data); end
      end
      step();
      step();
      step();
      #1;
    end
    bus.req_valid = 2'b00;
    #1;
    applied++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 1'b1 || bus.rsp_data !== 32'd7) begin miscompares++; $display("FAIL rr_rsp3: valid/id/data got %b/%h/%h want 1/1/7", bus.rsp_valid, bus.rsp_id, bus.rsp_data); end
    applied++; if (bus.req_ready !== 2'b00) begin miscompares++; $display("FAIL rr_no_grant: got %b want 00", bus.req_ready); end
  endtask

  task automatic test_flush_run();
    set_req(0, OP_ADD, 32'd1, 32'd2);
    #1;
    applied++; if (bus.req_ready !== 2'b01) begin miscompares++; $display("FAIL fr_ready: got %b want 01", bus.req_ready); end
    step();
    bus.req_valid[0] = 1'b0;
    set_req(1, OP_ADD, 32'd100, 32'd200);
    flush = 1'b1;
    #1;
    applied++; if (adu_start !== 1'b1 || bus.req_ready !== 2'b00) begin miscompares++; $display("FAIL fr_run: start/ready got %b/%b want 1/00", adu_start, bus.req_ready); end
    step();
    // Second flush while draining must have no effect.
    flush = 1'b1;
    #1;
    applied++; if (adu_start !== 1'b0 || busy !== 1'b1) begin miscompares++; $display("FAIL fr_drain: start/busy got %b/%b want 0/1", adu_start, busy); end
    applied++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 2'b00) begin miscompares++; $display("FAIL fr_drain_quiet: rsp/ready got %b/%b want 0/00", bus.rsp_valid, bus.req_ready); end
    step();
    flush = 1'b0;
    #1;
    applied++; if (bus.rsp_valid !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL fr_no_rsp: rsp/busy got %b/%b want 0/0", bus.rsp_valid, busy); end
    applied++; if (bus.req_ready !== 2'b10) begin miscompares++; $display("FAIL fr_next_grant: got %b want 10", bus.req_ready); end
    step();
    bus.req_valid[1] = 1'b0;
    step();
    step();
    #1;
    applied++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 1'b1 || bus.rsp_data !== 32'd300) begin miscompares++; $display("FAIL fr_after_rsp: valid/id/data got %b/%h/%h want 1/1/12c", bus.rsp_valid, bus.rsp_id, bus.rsp_data); end
    set_req(0, OP_ADD, 32'd4, 32'd4);
    #1;
    applied++; if (bus.req_ready !== 2'b01) begin miscompares++; $display("FAIL fd_ready: got %b want 01", bus.req_ready); end
    step();
    bus.req_valid[0] = 1'b0;
    step();
    flush = 1'b1;
    #1;
    applied++; if (busy !== 1'b1 || adu_done !== 1'b1) begin miscompares++; $display("FAIL fd_done_cycle: busy/done got %b/%b want 1/1", busy, adu_done); end
    step();
    flush = 1'b0;
    #1;
    applied++; if (bus.rsp_valid !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL fd_suppress: rsp/busy got %b/%b want 0/0", bus.rsp_valid, busy); end
  endtask

  task automatic test_flush_idle();
    set_req(0, OP_SUB, 32'd9, 32'd4);
    flush = 1'b1;
    #1;
    applied++; if (bus.req_ready !== 2'b00) begin miscompares++; $display("FAIL fi_blocked: got %b want 00", bus.req_ready); end
    step();
    flush = 1'b0;
    #1;
    applied++; if (busy !== 1'b0 || bus.req_ready !== 2'b01) begin miscompares++; $display("FAIL fi_grant: busy/ready got %b/%b want 0/01", busy, bus.req_ready); end
    step();
    bus.req_valid[0] = 1'b0;
    step();
    step();
    #1;
    applied++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 1'b0 || bus.rsp_data !== 32'd5) begin miscompares++; $display("FAIL fi_rsp: valid/id/data got %b/%h/%h want 1/0/5", bus.rsp_valid, bus.rsp_id, bus.rsp_data); end
  endtask

  task automatic test_async_reset();
    set_req(1, OP_ADD, 32'd3, 32'd3);
    #1;
    applied++; if (bus.req_ready !== 2'b10) begin miscompares++; $display("FAIL ar_ready: got %b want 10", bus.req_ready); end
    step();
    bus.req_valid[1] = 1'b0;
    #1;
    applied++; if (busy !== 1'b1 || adu_a !== 32'd3) begin miscompares++; $display("FAIL ar_run: busy/a got %b/%h want 1/3", busy, adu_a); end
    #1;
    rst_n = 1'b0;
    set_req(0, OP_ADD, 32'd20, 32'd22);
    set_req(1, OP_SUB, 32'd50, 32'd8);
    #1;
    applied++; if (busy !== 1'b0 || adu_start !== 1'b0) begin miscompares++; $display("FAIL ar_async_state: busy/start got %b/%b want 0/0", busy, adu_start); end
    applied++; if (adu_a !== 32'h0 || adu_b !== 32'h0 || bus.req_ready !== 2'b00) begin miscompares++; $display("FAIL ar_async_regs: a/b/ready got %h/%h/%b want 0/0/00", adu_a, adu_b, bus.req_ready); end
    step();
    step();
    #1;
    rst_n = 1'b1;
    #1;
    applied++; if (bus.req_ready !== 2'b01 || bus.rsp_valid !== 1'b0) begin miscompares++; $display("FAIL ar_first_win: ready/rsp got %b/%b want 01/0", bus.req_ready, bus.rsp_valid); end
    step();
    bus.req_valid = 2'b00;
    #1;
    applied++; if (bus.rsp_valid !== 1'b0) begin miscompares++; $display("FAIL ar_stale: got %b want 0", bus.rsp_valid); end
    step();
    step();
    #1;
    applied++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 1'b0 || bus.rsp_data !== 32'd42) begin miscompares++; $display("FAIL ar_rsp: valid/id/data got %b/%h/%h want 1/0/2a", bus.rsp_valid, bus.rsp_id, bus.rsp_data); end
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_op    = {OP_ADD, OP_ADD};
    bus.req_a     = '0;
    bus.req_b     = '0;
    test_reset();
    test_single_add();
    test_carry();
    test_compare();
    test_fairness();
    test_flush_run();
    test_flush_idle();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
